// File: rtl/led_sched_pkg.sv
// Shared definitions for the status-LED blink-code scheduler.
package led_sched_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int CLOCK_HZ        = 27_000_000;
    localparam int TICK_CYCLES_DEF = CLOCK_HZ / 2;
endpackage

// File: rtl/led_code_scheduler_if.sv
// Requester-side bundle: req/count in, ack/status/LED out.
interface led_code_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] count;
    logic [NUM_REQ-1:0]       ack;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;
    logic                     led;

    modport master (output req, count, input ack, busy, grant_id, led);
    modport slave  (input req, count, output ack, busy, grant_id, led);
endinterface

// File: rtl/led_tick_gen.sv
// Free-running modulo-TICK_CYCLES counter; one-cycle tick at the wrap, held off by clear.
module led_tick_gen
    import led_sched_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            TW   = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/led_code_scheduler.sv
// Fixed-priority arbiter plus blink-code sequencer driving the shared status LED.
module led_code_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 4,
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int GAP_TICKS   = 4
) (
    input logic                  clock,
    input logic                  reset,
    led_code_scheduler_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic [ID_W-1:0]    grant_q, grant_nxt;
    logic [NUM_REQ-1:0] ack_q, ack_nxt;
    logic               led_q, busy_q;
    logic               tick, tick_clr;
    logic               win;
    logic [ID_W-1:0]    win_id;

    assign tick_clr = (state == ST_IDLE);

    led_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (tick_clr),
        .tick  (tick)
    );

    // Scan downward so the lowest asserted index is the last one written.
    always_comb begin
        win    = 1'b0;
        win_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win    = 1'b1;
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        gap_cnt_nxt   = gap_cnt;
        grant_nxt     = grant_q;
        case (state)
            ST_IDLE: if (win) begin
                grant_nxt     = win_id;
                remaining_nxt = bus.count[win_id*CNT_W +: CNT_W];
                state_nxt     = (remaining_nxt != '0) ? ST_ON : ST_DONE;
            end
            ST_ON: if (tick) state_nxt = ST_OFF;
            ST_OFF: if (tick) begin
                remaining_nxt = remaining - 1'b1;
                if (remaining > 1)
                    state_nxt = ST_ON;
                else if (GAP_TICKS == 0)
                    state_nxt = ST_DONE;
                else begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = '0;
                end
            end
            ST_GAP: if (tick) begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = ST_DONE;
                else
                    gap_cnt_nxt = gap_cnt + 1'b1;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        ack_nxt = '0;
        if (state_nxt == ST_DONE) ack_nxt[grant_nxt] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            gap_cnt   <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            gap_cnt   <= gap_cnt_nxt;
            grant_q   <= grant_nxt;
            ack_q     <= ack_nxt;
            led_q     <= (state_nxt == ST_ON);
            busy_q    <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_q;
    assign bus.led      = led_q;
endmodule

// File: tb/tb_led_code_scheduler.sv
// Directed bench for led_code_scheduler with a short tick (T=4) and a 2-tick gap.
module tb_led_code_scheduler;
    localparam int T  = 4;
    localparam int G  = 2;
    localparam int NR = 4;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    led_code_scheduler_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    led_code_scheduler #(
        .NUM_REQ(NR), .CNT_W(CW), .TICK_CYCLES(T), .GAP_TICKS(G)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Called at cycle k=0 (just after the grant edge); walks the whole code.
    task automatic watch_code(input string tag, input int n, input int ack_k,
                              input int ack_exp, input int drop_k);
        int   led_bad  = 0;
        int   busy_bad = 0;
        int   ack_seen = -1;
        int   ack_val  = 0;
        int   ack_cnt  = 0;
        logic exp_led;
        for (int k = 0; k <= ack_k + 1; k++) begin
            if (k > 0) next_cycle();
            exp_led = (k < 2 * n * T) && ((k % (2 * T)) < T);
            if (bus.led !== exp_led) led_bad++;
            if (bus.busy !== (k <= ack_k)) busy_bad++;
            if (bus.ack !== '0) begin
                ack_cnt++;
                if (ack_seen < 0) begin
                    ack_seen = k;
                    ack_val  = int'(bus.ack);
                end
                bus.req = bus.req & ~bus.ack;
            end
            if (k == drop_k) bus.req = '0;
        end
        chk({tag, "_led_wave"}, led_bad, 0);
        chk({tag, "_busy_wave"}, busy_bad, 0);
        chk({tag, "_ack_cycle"}, ack_seen, ack_k);
        chk({tag, "_ack_value"}, ack_val, ack_exp);
        chk({tag, "_ack_width"}, ack_cnt, 1);
    endtask

    initial begin
        int ticks;
        bus.req   = '0;
        bus.count = '0;

        // reset held from time 0, released mid-run
        repeat (3) next_cycle();
        reset = 1'b0;
        chk("rst_led", int'(bus.led), 0);
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_grant", int'(bus.grant_id), 0);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (dut.tick) ticks++;
        end
        chk("idle_no_tick", ticks, 0);

        // req[2], count 3
        bus.count = 16'h0300;
        bus.req   = 4'b0100;
        next_cycle();
        chk("c3_grant", int'(bus.grant_id), 2);
        watch_code("c3", 3, 32, 4'b0100, -1);

        // req[0] count 1 and req[3] count 2 on the same edge
        bus.count = 16'h2001;
        bus.req   = 4'b1001;
        next_cycle();
        chk("pri_grant0", int'(bus.grant_id), 0);
        watch_code("pri0", 1, 16, 4'b0001, -1);
        next_cycle();
        chk("pri_grant3", int'(bus.grant_id), 3);
        watch_code("pri3", 2, 24, 4'b1000, -1);

        // req[1] with count 0
        bus.count = 16'h0000;
        bus.req   = 4'b0010;
        next_cycle();
        chk("z_grant", int'(bus.grant_id), 1);
        watch_code("z", 0, 0, 4'b0010, -1);

        // reset during the second ON of a count-3 code
        bus.count = 16'h0300;
        bus.req   = 4'b0100;
        next_cycle();
        repeat (9) next_cycle();
        chk("mid_led_on", int'(bus.led), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_led", int'(bus.led), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_ack", int'(bus.ack), 0);
        chk("mid_rst_grant", int'(bus.grant_id), 0);
        next_cycle();
        chk("mid_rst_hold_ack", int'(bus.ack), 0);
        reset = 1'b0;
        next_cycle();
        chk("rerun_grant", int'(bus.grant_id), 2);
        watch_code("rerun", 3, 32, 4'b0100, -1);

        // req[2] dropped 5 cycles after grant
        bus.count = 16'h0300;
        bus.req   = 4'b0100;
        next_cycle();
        chk("drop_grant", int'(bus.grant_id), 2);
        watch_code("drop", 3, 32, 4'b0100, 5);
        next_cycle();
        chk("drop_idle_busy", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_code_scheduler.md
# led_code_scheduler

Shares the board's single status LED between `NUM_REQ` requesters and sequences it as a blink code: N on/off pulses on a half-second time base, then an inter-code gap. Requesters use a req/ack handshake and are served one at a time under fixed priority. The block sits between the system status sources (heartbeat, error, link state) and the LED pin, and replaces any free-running toggle on that pin.

## Interface
- `NUM_REQ`, 4: number of requesters, from 2 to 8.
- `CNT_W`, 4: width of each pulse-count field.
- `TICK_CYCLES`, 13_500_000: clocks per tick (0.5 s at 27 MHz). Must be at least 2.
- `GAP_TICKS`, 4: ticks of LED-off gap after the last pulse. 0 is legal.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `count`  in  NUM_REQ*CNT_W  pulse count; field i is `[i*CNT_W +: CNT_W]`.
- `ack`  out  NUM_REQ  one-cycle completion pulse, one-hot.
- `busy`  out  1  a code is in progress.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `led`  out  1  LED drive, 1 = on.

## Operation
- All outputs are registered.
- Reset values: led=0, ack=0, busy=0, grant_id=0, state=IDLE, tick counter=0.
- States are IDLE, ON, OFF, GAP and DONE.
- **IDLE**
  - The tick generator is held cleared.
  - Each edge, the lowest-index asserted `req` wins.
  - On a win, the block latches the winner's index into `grant_id` and its count into `remaining`.
  - If count is nonzero, the next state is ON. If count is 0, the next state is DONE and the LED never lights.
- **ON** (led=1): on a tick, go to OFF.
- **OFF** (led=0): on a tick, decrement `remaining`.
  - If `remaining` was above 1, go to ON.
  - Otherwise go to GAP, or straight to DONE if GAP_TICKS is 0.
- **GAP** (led=0): count GAP_TICKS ticks, then go to DONE.
- **DONE**: hold `ack[grant_id]` high for exactly one cycle, then return to IDLE.
- `busy` is high in ON, OFF, GAP and DONE.
- Handshake rules:
  - `req` and `count` are sampled only at the grant edge.
  - Dropping `req` mid-code does not abort the code; it still completes and `ack` still pulses.
  - A `req` still high in the IDLE cycle after DONE is a new request. A requester deasserts `req` on the cycle it sees `ack`.
- Priority is fixed: there is no fairness guarantee, and a lower-index requester can starve higher indices.
- Asserting `reset` mid-code discards the code immediately. The LED goes off at once and no `ack` is issued. A request still held after reset release is re-arbitrated normally.

## Timing
- Let E0 be the grant edge and T = TICK_CYCLES.
- The tick fires combinationally when the tick counter equals T-1 and clear is not asserted. The counter then wraps to 0.
- The LED rises in the cycle after E0. Pulse k (k = 0..N-1) is high from E0+2kT to E0+(2k+1)T and low for the next T cycles.
- `ack` is high in the single cycle starting at E0+(2N+GAP_TICKS)T.
- With count 0, `ack` is high in the cycle immediately after E0.
- The earliest next grant edge is the edge ending the first IDLE cycle after DONE. The minimum dead time between codes is therefore 2 cycles.
- Widths:
  - the tick counter is $clog2(TICK_CYCLES) bits;
  - the gap counter is $clog2(GAP_TICKS+1) bits;
  - `remaining` is CNT_W bits and never wraps, since it is decremented only while it is at least 1.

## Structure
- Shared package `led_sched_pkg` holds:
  - the state encoding (IDLE, ON, OFF, GAP, DONE);
  - the default CLOCK_HZ = 27_000_000;
  - the TICK_CYCLES default, derived as CLOCK_HZ/2.
- Sub-module `led_tick_gen`:
  - parameter TICK_CYCLES;
  - ports clock, reset, clear and tick;
  - a free-running modulo-T counter with synchronous clear; tick is suppressed while clear is high.
- The arbiter, sequencer FSM and output registers live in the top module.

## Test plan
All cases run with TICK_CYCLES=4, GAP_TICKS=2 and NUM_REQ=4.
- Reset asserted mid-run, then released -> led=0, ack=0, busy=0 and grant_id=0 immediately; the first tick appears only after a grant.
- req[2] held with count 3 -> grant_id=2. LED high for 4 cycles, low for 4 cycles, three times. `ack` = 0100 for one cycle, 32 cycles after E0, then busy=0.
- req[0] (count 1) and req[3] (count 2) both raised on the same edge -> req[0] is served first and acked at E0+16. req[3] is granted 2 cycles later and acked 24 cycles after its grant.
- req[1] with count 0 -> ack[1] pulses the cycle after the grant, led stays 0, and busy is high for 1 cycle.
- reset pulsed during the second ON of a count-3 code, with req held -> LED drops at once and there is no `ack`. After release the code restarts from pulse 1, and the full 32-cycle sequence ends in `ack`.
- req[2] dropped 5 cycles after its grant -> the code still runs to completion and ack[2] pulses at E0+32.
